icache_ctrl: RTL
================

# icache_ctrl

Sequencing controller for the 2-way, 256-set instruction-cache SRAM bank (277-bit entries: 256-bit line, 20-bit tag, valid). Accepts fetch requests, performs lookup and hit detection, runs refills against the next memory level with a per-set LRU victim choice, and walks the array to invalidate it after reset or on flush. It is the only master of the bank's port.

## Interface
- ADDR_W, 32, request/memory address width
- LINE_W, 256, cache line width
- TAG_W, 20, stored tag width; tag = {1'b0, addr[31:13]}
- clka  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- req_valid / req_ready  in / out  1  fetch request handshake
- req_addr  in  32  fetch address; index = addr[12:5], offset addr[4:0] ignored
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_data  out  256  full line
- mem_req_valid / mem_req_ready  out / in  1  refill request handshake
- mem_req_addr  out  32  {req_addr[31:5], 5'b0}
- mem_rsp_valid  in  1  refill data strobe; no backpressure
- mem_rsp_data  in  256  refill line
- flush_req  in  1  single-cycle invalidate-all request
- flush_busy  out  1  flush pending or running
- sram_ena, sram_wea  out  1  bank enable / write enable
- sram_addr  out  8  set index
- sram_wmask  out  2  way write mask (bit0 = way0)
- sram_dina  out  277  {data[255:0], tag[19:0], valid}
- sram_douta  in  554  [276:0] way0, [553:277] way1; valid the cycle after a read

## Operation
- States: FLUSH, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL, RESP.
- Reset: state FLUSH, flush counter 0, all 256 LRU bits 0, every output 0 except flush_busy=1.
- FLUSH: each cycle sram_ena=1, wea=1, wmask=2'b11, dina=0, addr=counter; LRU[counter]=0; after counter 255 go IDLE, clear flush_busy.
- IDLE: req_ready=1 only here with no flush pending. Pending flush has priority over req_valid (go FLUSH, req_ready=0). On accept: latch addr, drive a read same cycle (ena=1, wea=0, addr=req_addr[12:5]) -> LOOKUP.
- LOOKUP: hit_w = valid_w & (tag_w == latched tag); way0 wins if both hit. Hit: rsp_data <= hit line, LRU[idx] <= ~hit way, -> RESP. Miss: victim = first invalid way (way0 first), else LRU[idx]; -> MISS_REQ.
- MISS_REQ: mem_req_valid=1, address stable until mem_req_ready -> MISS_WAIT.
- MISS_WAIT: on mem_rsp_valid capture data -> REFILL. mem_rsp_valid in any other state is ignored.
- REFILL: one write: ena=1, wea=1, wmask=onehot(victim), dina={line, tag, 1'b1}; LRU[idx] <= ~victim; rsp_data <= line; -> RESP.
- RESP: rsp_valid=1, rsp_data held until rsp_ready -> IDLE.
- LRU bit semantic: value is the next victim way.
- flush_req in any state sets flush_pend and flush_busy next cycle; an in-flight miss completes, including its response, before FLUSH starts. flush_req during FLUSH is absorbed; the walk does not restart.
- sram_ena=0 in every cycle not listed above.

## Timing
- Hit: accept at cycle T, LOOKUP at T+1, rsp_valid at T+2.
- Miss: mem_req_valid at T+2. REFILL is the cycle after mem_rsp_valid. rsp_valid follows one cycle later.
- Back-to-back hits: next accept no earlier than the cycle after the rsp handshake, giving a throughput of 1 per 3 cycles minimum.
- Flush: 256 cycles of writes; flush_busy falls and req_ready rises on the same cycle.
- Reset mid-miss: the outstanding mem request is abandoned. The late mem_rsp_valid is ignored. A full flush is rerun.

## Test plan
- Reset release -> 256 writes, addr 0x00..0xFF, wmask 2'b11, dina 0; req_ready=0 throughout; flush_busy 1->0 as req_ready rises.
- Cold miss at addr 0x10CF15C0 (idx 0xAE, tag 0x08678) -> mem_req_addr 0x10CF15C0; mem_rsp data D -> write idx 0xAE, wmask 01, dina {D, 20'h08678, 1}; rsp_data=D.
- Repeat 0x10CF15C0 -> rsp_valid at T+2, rsp_data=D, no mem_req_valid.
- Tags A, B, C mapping to the same index; sequence miss A, miss B, hit A, miss C -> A fills way0, B fills way1, C evicts way1 (wmask 10); A still hits.
- Hold rsp_ready=0 for 3 cycles and mem_req_ready=0 for 4 cycles -> rsp_valid/rsp_data and mem_req_valid/mem_req_addr stable until the handshake; no duplicate refill write.
- flush_req pulse during MISS_WAIT -> refill and response complete, then a 256-cycle flush; the next request to the same address misses.

Source files
------------

// File: rtl/icache_ctrl.sv
`default_nettype none
// ==== icache_ctrl : 2-way / 256-set I-cache bank sequencer (lookup, LRU refill, invalidate walk) ====
// ==== rev 1.0                                                                                    ====
module icache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 20
) (
  input  logic                           clka,
  input  logic                           rstn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [LINE_W-1:0]              rsp_data,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [ADDR_W-1:0]              mem_req_addr,
  input  logic                           mem_rsp_valid,
  input  logic [LINE_W-1:0]              mem_rsp_data,
  input  logic                           flush_req,
  output logic                           flush_busy,
  output logic                           sram_ena,
  output logic                           sram_wea,
  output logic [7:0]                     sram_addr,
  output logic [1:0]                     sram_wmask,
  output logic [LINE_W+TAG_W:0]          sram_dina,
  input  logic [2*(LINE_W+TAG_W+1)-1:0]  sram_douta
);

  localparam int ENT_W     = LINE_W + TAG_W + 1;
  localparam int TAG_SRC_W = ADDR_W - 13;

  typedef enum logic [2:0] {
    S_FLUSH     = 3'd0,
    S_IDLE      = 3'd1,
    S_LOOKUP    = 3'd2,
    S_MISS_REQ  = 3'd3,
    S_MISS_WAIT = 3'd4,
    S_REFILL    = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  state_t              state, state_nx;
  logic [7:0]          flush_cnt;
  logic [255:0]        lru;
  logic                flush_pend;
  logic [ADDR_W-1:5]   addr_q;
  logic                victim;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   rsp_q;

  logic [7:0]          idx;
  logic [TAG_W-1:0]    tag_q;
  logic                v0, v1, hit0, hit1, victim_sel;
  logic [TAG_W-1:0]    t0, t1;
  logic [LINE_W-1:0]   d0, d1;
  logic                unused_offset;

  assign unused_offset = ^req_addr[4:0];
  assign idx      = addr_q[12:5];
  assign tag_q    = {{(TAG_W-TAG_SRC_W){1'b0}}, addr_q[ADDR_W-1:13]};
  assign rsp_data = rsp_q;

  // Entry layout per way: {data, tag, valid}
  assign v0   = sram_douta[0];
  assign t0   = sram_douta[TAG_W:1];
  assign d0   = sram_douta[ENT_W-1:TAG_W+1];
  assign v1   = sram_douta[ENT_W];
  assign t1   = sram_douta[ENT_W+TAG_W:ENT_W+1];
  assign d1   = sram_douta[2*ENT_W-1:ENT_W+TAG_W+1];
  assign hit0 = v0 && (t0 == tag_q);
  assign hit1 = v1 && (t1 == tag_q);
  assign victim_sel = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx]);

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    sram_ena      = 1'b0;
    sram_wea      = 1'b0;
    sram_addr     = '0;
    sram_wmask    = '0;
    sram_dina     = '0;
    flush_busy    = flush_pend || (state == S_FLUSH);
    // Outputs are held quiet while reset is asserted
    if (!rstn) begin
      flush_busy = 1'b1;
      state_nx   = S_FLUSH;
    end else begin
      case (state)
        S_FLUSH: begin
          sram_ena   = 1'b1;
          sram_wea   = 1'b1;
          sram_wmask = 2'b11;
          sram_addr  = flush_cnt;
          if (flush_cnt == 8'hFF) state_nx = S_IDLE;
        end
        S_IDLE: begin
          if (flush_pend) begin
            state_nx = S_FLUSH;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              sram_ena  = 1'b1;
              sram_addr = req_addr[12:5];
              state_nx  = S_LOOKUP;
            end
          end
        end
        S_LOOKUP:    state_nx = (hit0 || hit1) ? S_RESP : S_MISS_REQ;
        S_MISS_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {addr_q, 5'b0};
          if (mem_req_ready) state_nx = S_MISS_WAIT;
        end
        S_MISS_WAIT: if (mem_rsp_valid) state_nx = S_REFILL;
        S_REFILL: begin
          sram_ena   = 1'b1;
          sram_wea   = 1'b1;
          sram_addr  = idx;
          sram_wmask = victim ? 2'b10 : 2'b01;
          sram_dina  = {line_q, tag_q, 1'b1};
          state_nx   = S_RESP;
        end
        S_RESP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) state_nx = S_IDLE;
        end
        default:     state_nx = S_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (!rstn) begin
      state      <= S_FLUSH;
      flush_cnt  <= '0;
      lru        <= '0;
      flush_pend <= 1'b0;
      addr_q     <= '0;
      victim     <= 1'b0;
      line_q     <= '0;
      rsp_q      <= '0;
    end else begin
      state <= state_nx;
      // A request arriving while the walk runs is already covered by it
      if (flush_req && state != S_FLUSH) flush_pend <= 1'b1;
      if (state == S_IDLE && flush_pend) flush_pend <= 1'b0;
      case (state)
        S_FLUSH: begin
          lru[flush_cnt] <= 1'b0;
          flush_cnt      <= flush_cnt + 8'd1;
        end
        S_IDLE: if (!flush_pend && req_valid) addr_q <= req_addr[ADDR_W-1:5];
        S_LOOKUP: begin
          if (hit0) begin
            rsp_q    <= d0;
            lru[idx] <= 1'b1;
          end else if (hit1) begin
            rsp_q    <= d1;
            lru[idx] <= 1'b0;
          end else begin
            victim   <= victim_sel;
          end
        end
        S_MISS_WAIT: if (mem_rsp_valid) line_q <= mem_rsp_data;
        S_REFILL: begin
          lru[idx] <= ~victim;
          rsp_q    <= line_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
